// File: rtl/fpcvt_pkg.sv
`default_nettype none
// =====================================================================
// Module  : fpcvt_pkg
// Desc    : Shared widths and FSM encoding for the FPCVT scheduler.
// Revision: 1.0
// =====================================================================
package fpcvt_pkg;

    localparam int DATA_W = 12;
    localparam int EXP_W  = 3;
    localparam int FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fpcvt.sv
`default_nettype none
// =====================================================================
// Module  : fpcvt
// Desc    : 12-bit two's complement to 8-bit float (S, E[2:0], F[3:0]).
// Revision: 1.0
// =====================================================================
module fpcvt
    import fpcvt_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    output logic              s,
    output logic [EXP_W-1:0]  e,
    output logic [FRAC_W-1:0] f
);

    logic [DATA_W-1:0] w_mag;
    logic [EXP_W-1:0]  w_shift;
    logic [DATA_W-1:0] w_shifted;
    logic              w_round;
    logic [FRAC_W:0]   w_sum;

    always_comb begin
        w_mag   = d[DATA_W-1] ? (~d + 1'b1) : d;
        w_shift = '0;
        // Highest set bit above the 4-bit window sets the exponent.
        for (int i = FRAC_W; i < DATA_W - 1; i++) begin
            if (w_mag[i]) begin
                w_shift = EXP_W'(i - FRAC_W + 1);
            end
        end
        w_shifted = w_mag >> w_shift;
        w_round   = (w_shift != '0) ? w_mag[w_shift - 1'b1] : 1'b0;
        w_sum     = {1'b0, w_shifted[FRAC_W-1:0]} + {{FRAC_W{1'b0}}, w_round};

        s = d[DATA_W-1];
        e = w_shift;
        f = w_sum[FRAC_W-1:0];
        if (w_mag[DATA_W-1]) begin
            e = '1;
            f = '1;
        end else if (w_sum[FRAC_W]) begin
            if (w_shift == '1) begin
                e = '1;
                f = '1;
            end else begin
                e = w_shift + 1'b1;
                f = w_sum[FRAC_W:1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpcvt_scheduler_rr_arbiter.sv
`default_nettype none
// =====================================================================
// Module  : rr_arbiter
// Desc    : Round-robin grant search starting at ptr, wrapping around.
// Revision: 1.0
// =====================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   grant_idx
);

    int               w_idx;
    logic [TAG_W-1:0] w_sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_idx     = 0;
        w_sel     = '0;
        // Walk from the farthest candidate back to ptr so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_sel = TAG_W'(w_idx);
            if (enable && req[w_sel]) begin
                grant        = '0;
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpcvt_scheduler.sv
`default_nettype none
// =====================================================================
// Module  : fpcvt_scheduler
// Desc    : Round-robin sharing of one FPCVT among NUM_REQ requesters.
// Revision: 1.0
// =====================================================================
module fpcvt_scheduler
    import fpcvt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_s,
    output logic [EXP_W-1:0]          out_e,
    output logic [FRAC_W-1:0]         out_f,
    output logic                      busy,
    output logic [CNT_W-1:0]          conv_count
);

    state_t              r_state;
    state_t              w_next_state;
    logic [TAG_W-1:0]    r_ptr;
    logic [TAG_W-1:0]    tag_reg;
    logic [DATA_W-1:0]   d_reg;
    logic [NUM_REQ-1:0]  w_grant;
    logic [TAG_W-1:0]    w_grant_idx;
    logic                w_idle;
    logic                w_accept;
    logic                w_out_hs;
    logic                w_cvt_s;
    logic [EXP_W-1:0]    w_cvt_e;
    logic [FRAC_W-1:0]   w_cvt_f;

    assign w_idle    = (r_state == IDLE);
    assign req_ready = w_grant;
    assign w_accept  = |(req_valid & w_grant);
    assign w_out_hs  = (r_state == RESP) & out_valid & out_ready;
    assign busy      = ~w_idle;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .enable    (w_idle),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    fpcvt u_cvt (
        .d (d_reg),
        .s (w_cvt_s),
        .e (w_cvt_e),
        .f (w_cvt_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = CONV;
            CONV:    w_next_state = RESP;
            RESP:    if (w_out_hs) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            d_reg      <= '0;
            tag_reg    <= '0;
            out_valid  <= 1'b0;
            out_tag    <= '0;
            out_s      <= 1'b0;
            out_e      <= '0;
            out_f      <= '0;
            conv_count <= '0;
        end else begin
            if (w_accept) begin
                d_reg   <= req_data[w_grant_idx*DATA_W +: DATA_W];
                tag_reg <= w_grant_idx;
                r_ptr   <= (w_grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_state == CONV) begin
                out_s     <= w_cvt_s;
                out_e     <= w_cvt_e;
                out_f     <= w_cvt_f;
                out_tag   <= tag_reg;
                out_valid <= 1'b1;
            end
            // Fields stay put after the handshake; only valid drops.
            if (w_out_hs) begin
                out_valid  <= 1'b0;
                conv_count <= conv_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_scheduler.sv
`default_nettype none
// =====================================================================
// Module  : tb_fpcvt_scheduler
// Desc    : Self-checking bench: vector table, directed corners, random.
// Revision: 1.0
// =====================================================================
module tb_fpcvt_scheduler;

    localparam int NR = 4;
    localparam int TW = 2;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [12*NR-1:0] req_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [TW-1:0]   out_tag;
    logic            out_s;
    logic [2:0]      out_e;
    logic [3:0]      out_f;
    logic            busy;
    logic [CW-1:0]   conv_count;

    int total = 0;
    int bad = 0;
    int m_count = 0;
    int m_ptr = 0;

    fpcvt_scheduler #(.NUM_REQ(NR), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_s      (out_s),
        .out_e      (out_e),
        .out_f      (out_f),
        .busy       (busy),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          idx;
        logic [11:0] data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Smallest exponent whose truncated quotient fits 4 bits, then round half up.
    function automatic logic [7:0] ref_cvt(input logic [11:0] d);
        int v;
        int e;
        int f;
        logic s;
        v = int'($signed(d));
        s = (v < 0);
        if (s) v = -v;
        e = 0;
        while ((v >> e) > 15) e++;
        f = (e == 0) ? v : ((v + (1 << (e - 1))) >> e);
        if (f == 16) begin
            e++;
            f = 8;
        end
        if (e > 7) begin
            e = 7;
            f = 15;
        end
        return {s, 3'(e), 4'(f)};
    endfunction

    task automatic check_result(input string name, input logic [1:0] tag, input logic [7:0] exp);
        check(name, {21'd0, out_valid, out_tag, out_s, out_e, out_f}, {21'd0, 1'b1, tag, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_count = 0;
        m_ptr = 0;
    endtask

    task automatic serve(input string name, input int idx, input logic [11:0] data, input logic [7:0] exp);
        logic [NR-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        @(negedge clk);
        req_valid = oh;
        req_data[idx*12 +: 12] = data;
        #1 check({name, "_ready"}, {28'd0, req_ready}, {28'd0, oh});
        @(negedge clk);
        req_valid = '0;
        #1 check({name, "_conv"}, {26'd0, busy, out_valid, req_ready}, {26'd0, 1'b1, 1'b0, 4'd0});
        @(negedge clk);
        #1 check_result({name, "_res"}, 2'(idx), exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_count = (m_count + 1) % 16;
        m_ptr = (idx + 1) % NR;
        #1 check({name, "_cnt"}, {27'd0, out_valid, conv_count}, {27'd0, 1'b0, 4'(m_count)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NR-1:0] oh;
        logic [11:0]   dat;
        logic [7:0]    exp_res;
        logic [1:0]    exp_tag;
        logic [NR-1:0] acc_last;
        int            pend;
        int            g;
        bit            found;

        vecs[0] = '{"v108",  2, 12'h06C, {1'b0, 3'd3, 4'd14}};
        vecs[1] = '{"vzero", 1, 12'h000, {1'b0, 3'd0, 4'd0}};
        vecs[2] = '{"vmin",  1, 12'h800, {1'b1, 3'd7, 4'd15}};
        vecs[3] = '{"vmax",  1, 12'h7FF, {1'b0, 3'd7, 4'd15}};
        vecs[4] = '{"vneg1", 1, 12'hFFF, {1'b1, 3'd0, 4'd1}};
        vecs[5] = '{"v422",  0, 12'h1A6, {1'b0, 3'd5, 4'd13}};
        vecs[6] = '{"vcarry",3, 12'h0F8, {1'b0, 3'd5, 4'd8}};
        vecs[7] = '{"vm108", 2, 12'hF94, {1'b1, 3'd3, 4'd14}};

        @(negedge clk);
        #1 check("reset_outs", {10'd0, req_ready, out_valid, out_tag, out_s, out_e, out_f, busy, conv_count},
                 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            serve(vecs[i].name, vecs[i].idx, vecs[i].data, vecs[i].exp);
        end

        // All four requesters valid from reset: strict rotation, one accept per 3 cycles.
        do_reset();
        req_valid = '1;
        for (int i = 0; i < NR; i++) req_data[i*12 +: 12] = 12'h1A6;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            oh = '0;
            oh[k % NR] = 1'b1;
            #1 check("rr_grant", {28'd0, req_ready}, {28'd0, oh});
            @(negedge clk);
            #1 check("rr_conv_ready", {28'd0, req_ready}, 32'd0);
            @(negedge clk);
            #1 check_result("rr_res", 2'(k % NR), {1'b0, 3'd5, 4'd13});
            @(negedge clk);
        end
        req_valid = '0;
        out_ready = 1'b0;
        m_count = 5;
        #1 check("rr_count", {28'd0, conv_count}, 32'(m_count));

        // Backpressure on requester 3 with everyone else clamoring.
        @(negedge clk);
        req_valid = 4'b1000;
        req_data[3*12 +: 12] = 12'h0F8;
        #1 check("bp_ready", {28'd0, req_ready}, 32'h8);
        @(negedge clk);
        req_valid = '1;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            #1 check_result("bp_hold", 2'd3, {1'b0, 3'd5, 4'd8});
            check("bp_busy", {27'd0, busy, req_ready}, {27'd0, 1'b1, 4'd0});
            @(negedge clk);
        end
        req_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_count = (m_count + 1) % 16;
        #1 check("bp_hs", {27'd0, out_valid, conv_count}, {27'd0, 1'b0, 4'(m_count)});
        @(negedge clk);
        #1 check("bp_single", {27'd0, busy, conv_count}, {27'd0, 1'b0, 4'(m_count)});

        // Asynchronous reset while the result of requester 2 waits in RESP.
        @(negedge clk);
        req_valid = 4'b0100;
        req_data[2*12 +: 12] = 12'h06C;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1 check("arst_pre", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("arst_outs", {10'd0, req_ready, out_valid, out_tag, out_s, out_e, out_f, busy, conv_count},
                 32'd0);
        m_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NR; i++) req_data[i*12 +: 12] = 12'h06C;
        #1 check("arst_ptr0", {28'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1 check_result("arst_next", 2'd0, {1'b0, 3'd3, 4'd14});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1 check("arst_cnt", {28'd0, conv_count}, 32'd1);

        // Counter wrap with a 4-bit counter.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            g = $urandom_range(0, NR - 1);
            dat = 12'($urandom);
            serve("wrap", g, dat, ref_cvt(dat));
        end
        check("wrap_zero", {28'd0, conv_count}, 32'd0);

        // Random traffic against a transaction-level model.
        do_reset();
        pend = -1;
        acc_last = '0;
        exp_res = '0;
        exp_tag = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || acc_last[i]) begin
                    req_data[i*12 +: 12] = 12'($urandom);
                end
                req_valid[i] = ($urandom_range(0, 1) == 1);
            end
            #1;
            found = 1'b0;
            g = 0;
            oh = '0;
            if (pend < 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (!found && req_valid[(m_ptr + k) % NR]) begin
                        found = 1'b1;
                        g = (m_ptr + k) % NR;
                    end
                end
                if (found) oh[g] = 1'b1;
            end
            check("rnd_ready", {28'd0, req_ready}, {28'd0, oh});
            check("rnd_busy", {31'd0, busy}, {31'd0, (pend >= 0)});
            if (pend >= 1) check_result("rnd_res", exp_tag, exp_res);
            else check("rnd_idle_ov", {31'd0, out_valid}, 32'd0);
            check("rnd_count", {28'd0, conv_count}, 32'(m_count));

            acc_last = '0;
            if (found) begin
                exp_tag = 2'(g);
                exp_res = ref_cvt(req_data[g*12 +: 12]);
                m_ptr = (g + 1) % NR;
                pend = 0;
                acc_last[g] = 1'b1;
            end else if (pend == 0) begin
                pend = 1;
            end else if (pend >= 1 && out_ready) begin
                pend = -1;
                m_count = (m_count + 1) % 16;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
